// File: rtl/out_display_scanner.sv
// Time-multiplexed 4-digit hex driver for the OUT_MSB/OUT_LSB register pair.
// A pending/shown double buffer confines value changes to frame boundaries.
module out_display_scanner #(
  parameter int REFRESH_DIV        = 50000,
  parameter int LEADING_ZERO_BLANK = 1,
  parameter int DP_SEPARATOR       = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       update_req,
  input  logic [7:0] msb_in,
  input  logic [7:0] lsb_in,
  input  logic       display_enable,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_done
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       digit_q, digit_d;
  logic [15:0]      pending_q, pending_d;
  logic             pending_valid_q, pending_valid_d;
  logic [15:0]      shown_q, shown_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             frame_done_q, frame_done_d;

  logic             slot_end;
  logic             boundary;
  logic             blank;
  logic [3:0]       nib;
  logic [3:0]       nibbles [4];
  logic [3:0]       upper_zero;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // upper_zero[k]: nibbles k..3 of the shown value are all zero.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_nib
      assign nibbles[gi]    = shown_q[4*gi +: 4];
      assign upper_zero[gi] = (shown_q[15:4*gi] == '0);
    end
  endgenerate

  assign slot_end = (cnt_q == CNT_LAST);
  assign boundary = slot_end && (digit_q == 2'd0);
  assign nib      = nibbles[digit_q];
  assign blank    = (LEADING_ZERO_BLANK != 0) && (digit_q != 2'd0) && upper_zero[digit_q];

  always_comb begin
    cnt_d           = slot_end ? '0 : cnt_q + CNT_W'(1);
    digit_d         = slot_end ? digit_q - 2'd1 : digit_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    shown_d         = shown_q;

    if (update_req) begin
      pending_d       = {msb_in, lsb_in};
      pending_valid_d = 1'b1;
    end

    // A strobe landing on the boundary edge bypasses the pending buffer.
    if (boundary) begin
      pending_valid_d = 1'b0;
      if (update_req)
        shown_d = {msb_in, lsb_in};
      else if (pending_valid_q)
        shown_d = pending_q;
    end

    an_d  = 4'b1111;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (display_enable && !blank) begin
      an_d  = ~(4'b0001 << digit_q);
      seg_d = hex_to_seg(nib);
      dp_d  = !((DP_SEPARATOR != 0) && (digit_q == 2'd2));
    end

    frame_done_d = boundary;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q           <= '0;
      digit_q         <= 2'd3;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      shown_q         <= '0;
      an_q            <= 4'b1111;
      seg_q           <= 7'h7F;
      dp_q            <= 1'b1;
      frame_done_q    <= 1'b0;
    end else begin
      cnt_q           <= cnt_d;
      digit_q         <= digit_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      shown_q         <= shown_d;
      an_q            <= an_d;
      seg_q           <= seg_d;
      dp_q            <= dp_d;
      frame_done_q    <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_out_display_scanner.sv
// Directed bench: two scanners (blanking off / on) share one stimulus stream;
// each frame is checked slot by slot against hand-computed patterns.
module tb_out_display_scanner;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       update_req = 1'b0;
  logic [7:0] msb_in = 8'h00;
  logic [7:0] lsb_in = 8'h00;
  logic       display_enable = 1'b1;
  logic [3:0] an_a, an_b;
  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b, fd_a, fd_b;

  always #5 clk = ~clk;

  out_display_scanner #(.REFRESH_DIV(4), .LEADING_ZERO_BLANK(0), .DP_SEPARATOR(1)) dut_a (
    .clk(clk), .reset(reset), .update_req(update_req), .msb_in(msb_in), .lsb_in(lsb_in),
    .display_enable(display_enable), .an(an_a), .seg(seg_a), .dp(dp_a), .frame_done(fd_a)
  );

  out_display_scanner #(.REFRESH_DIV(4), .LEADING_ZERO_BLANK(1), .DP_SEPARATOR(1)) dut_b (
    .clk(clk), .reset(reset), .update_req(update_req), .msb_in(msb_in), .lsb_in(lsb_in),
    .display_enable(display_enable), .an(an_b), .seg(seg_b), .dp(dp_b), .frame_done(fd_b)
  );

  // Per-frame patterns, slot order digit 3,2,1,0 from MSB down; _a no blanking, _b blanking.
  typedef struct {
    logic [15:0] val;
    logic [15:0] an_a;
    logic [27:0] seg_a;
    logic [3:0]  dp_a;
    logic [15:0] an_b;
    logic [27:0] seg_b;
    logic [3:0]  dp_b;
  } vec_t;

  vec_t vec [7];
  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  task automatic chk(input string name, input logic [27:0] act, input logic [27:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d actual=%h required=%h", name, edge_n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic wait_mod(input int m);
    for (int k = 0; k < 16 && (edge_n % 16) != m; k++) tick();
  endtask

  task automatic send(input logic [15:0] v);
    update_req = 1'b1;
    msb_in = v[15:8];
    lsb_in = v[7:0];
    tick();
    update_req = 1'b0;
    msb_in = 8'hxx;
    lsb_in = 8'hxx;
  endtask

  task automatic check_dark(input string name);
    chk({name, "_an_a"}, 28'(an_a), 28'hF);
    chk({name, "_seg_a"}, 28'(seg_a), 28'h7F);
    chk({name, "_dp_a"}, 28'(dp_a), 28'h1);
    chk({name, "_an_b"}, 28'(an_b), 28'hF);
    chk({name, "_seg_b"}, 28'(seg_b), 28'h7F);
    chk({name, "_dp_b"}, 28'(dp_b), 28'h1);
  endtask

  // Entry at a boundary (edge_n % 16 == 0); checks the full following frame.
  task automatic check_frame(input int idx);
    for (int s = 0; s < 4; s++) begin
      tick();
      chk($sformatf("v%0d_s%0d_an_a", idx, s), 28'(an_a), 28'(vec[idx].an_a[15-4*s -: 4]));
      chk($sformatf("v%0d_s%0d_seg_a", idx, s), 28'(seg_a), 28'(vec[idx].seg_a[27-7*s -: 7]));
      chk($sformatf("v%0d_s%0d_dp_a", idx, s), 28'(dp_a), 28'(vec[idx].dp_a[3-s]));
      chk($sformatf("v%0d_s%0d_an_b", idx, s), 28'(an_b), 28'(vec[idx].an_b[15-4*s -: 4]));
      chk($sformatf("v%0d_s%0d_seg_b", idx, s), 28'(seg_b), 28'(vec[idx].seg_b[27-7*s -: 7]));
      chk($sformatf("v%0d_s%0d_dp_b", idx, s), 28'(dp_b), 28'(vec[idx].dp_b[3-s]));
      chk($sformatf("v%0d_s%0d_fd", idx, s), 28'({fd_a, fd_b}), 28'h0);
      repeat (3) tick();
    end
    chk($sformatf("v%0d_frame_done", idx), 28'({fd_a, fd_b}), 28'h3);
    $display("frame v%0d value %h checked (checks=%0d)", idx, vec[idx].val, checks);
  endtask

  initial begin
    vec[0] = '{16'h12AB, 16'h7BDE, {7'h79, 7'h24, 7'h08, 7'h03}, 4'b1011,
                         16'h7BDE, {7'h79, 7'h24, 7'h08, 7'h03}, 4'b1011};
    vec[1] = '{16'h0005, 16'h7BDE, {7'h40, 7'h40, 7'h40, 7'h12}, 4'b1011,
                         16'hFFFE, {7'h7F, 7'h7F, 7'h7F, 7'h12}, 4'b1111};
    vec[2] = '{16'h0000, 16'h7BDE, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1011,
                         16'hFFFE, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111};
    vec[3] = '{16'h3C9E, 16'h7BDE, {7'h30, 7'h46, 7'h10, 7'h06}, 4'b1011,
                         16'h7BDE, {7'h30, 7'h46, 7'h10, 7'h06}, 4'b1011};
    vec[4] = '{16'h0708, 16'h7BDE, {7'h40, 7'h78, 7'h40, 7'h00}, 4'b1011,
                         16'hFBDE, {7'h7F, 7'h78, 7'h40, 7'h00}, 4'b1011};
    vec[5] = '{16'h00F0, 16'h7BDE, {7'h40, 7'h40, 7'h0E, 7'h40}, 4'b1011,
                         16'hFFDE, {7'h7F, 7'h7F, 7'h0E, 7'h40}, 4'b1111};
    vec[6] = '{16'h2222, 16'h7BDE, {7'h24, 7'h24, 7'h24, 7'h24}, 4'b1011,
                         16'h7BDE, {7'h24, 7'h24, 7'h24, 7'h24}, 4'b1011};

    // Power-on reset.
    repeat (3) begin
      tick();
      check_dark("por");
      chk("por_fd", 28'({fd_a, fd_b}), 28'h0);
    end
    reset = 1'b1;
    edge_n = 0;

    // One mid-frame update per vector; old value holds until the boundary.
    for (int i = 0; i < 6; i++) begin
      wait_mod(6);
      send(vec[i].val);
      wait_mod(15);
      chk($sformatf("v%0d_old_seg0", i), 28'(seg_a),
          (i == 0) ? 28'h40 : 28'(vec[i-1].seg_a[6:0]));
      tick();
      check_frame(i);
    end

    // Last capture wins.
    wait_mod(3);
    send(16'h1111);
    wait_mod(8);
    send(16'h2222);
    wait_mod(0);
    check_frame(6);

    // Strobe on the boundary edge, with an older value still pending.
    wait_mod(3);
    send(16'h1111);
    wait_mod(15);
    send(16'h00F0);
    check_frame(5);
    chk("bypass_pending_valid", 28'(dut_a.pending_valid_q), 28'h0);
    check_frame(5);

    // Display disabled for 20 cycles; scan and frame_done keep running.
    display_enable = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      check_dark($sformatf("dis%0d", k));
      chk($sformatf("dis%0d_fd", k), 28'({fd_a, fd_b}),
          ((edge_n % 16) == 0) ? 28'h3 : 28'h0);
    end
    display_enable = 1'b1;
    tick();
    chk("reen_an_a", 28'(an_a), 28'hB);
    chk("reen_seg_a", 28'(seg_a), 28'h40);
    chk("reen_dp_a", 28'(dp_a), 28'h0);
    chk("reen_an_b", 28'(an_b), 28'hF);
    chk("reen_seg_b", 28'(seg_b), 28'h7F);
    $display("display disable/re-enable checked (checks=%0d)", checks);

    // Reset mid-frame with a value pending, right before a boundary.
    wait_mod(6);
    send(16'h3C9E);
    wait_mod(15);
    reset = 1'b0;
    repeat (3) begin
      tick();
      check_dark("mrst");
      chk("mrst_fd", 28'({fd_a, fd_b}), 28'h0);
    end
    reset = 1'b1;
    edge_n = 0;
    for (int k = 1; k < 16; k++) begin
      tick();
      chk($sformatf("rel%0d_fd", k), 28'({fd_a, fd_b}), 28'h0);
    end
    tick();
    chk("rel16_fd", 28'({fd_a, fd_b}), 28'h3);
    check_frame(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/out_display_scanner.md
# out_display_scanner

Display driver that consumes the 16-bit value held in the CPU's OUT_MSB/OUT_LSB output registers and time-multiplexes it onto a 4-digit, common-anode, active-low seven-segment display as four hex digits. It sits after the output register pair, on the reader side of the OE/output interface. A pending/shown double buffer ensures a new value only appears at a frame boundary, so a displayed frame never mixes old and new digits. Refresh divider, digit scan and all display outputs are registered.

## Interface
- REFRESH_DIV, 50000: clock cycles per digit slot; legal range ≥ 2.
- LEADING_ZERO_BLANK, 1: 1 blanks leading zero digits 3..1; digit 0 is never blanked.
- DP_SEPARATOR, 1: 1 lights the decimal point on digit 2, separating the MSB and LSB bytes.
- clk  in  1  clock, posedge.
- reset  in  1  reset, synchronous, active-low.
- update_req  in  1  single-cycle strobe: capture {msb_in, lsb_in} this cycle.
- msb_in  in  8  OUT_MSB register value, shown as digits 3 and 2.
- lsb_in  in  8  OUT_LSB register value, shown as digits 1 and 0.
- display_enable  in  1  0 forces the display dark; the scan keeps running.
- an  out  4  anode selects, active-low; an[k] drives digit k.
- seg  out  7  segments, active-low, seg[6:0] = g f e d c b a.
- dp  out  1  decimal point, active-low.
- frame_done  out  1  one-cycle pulse after each completed 4-digit frame.

## Operation
- State:
  - cnt: 0..REFRESH_DIV-1.
  - digit: 2 bits; scan order 3 → 2 → 1 → 0 → 3.
  - pending: 16 bits.
  - pending_valid: 1 bit.
  - shown: 16 bits.
- Divider: cnt increments every cycle. At cnt == REFRESH_DIV-1, cnt wraps to 0 and digit decrements modulo 4.
- Frame boundary: the edge at which cnt == REFRESH_DIV-1 and digit == 0.
- Capture: when update_req = 1, pending ← {msb_in, lsb_in} and pending_valid ← 1. A later update_req in the same frame overwrites pending, so the last capture wins.
- Transfer, at a frame boundary:
  - update_req = 1 on the same edge: shown ← {msb_in, lsb_in} directly and pending_valid ← 0 (bypass).
  - Otherwise, if pending_valid = 1: shown ← pending and pending_valid ← 0.
  - Otherwise: shown holds its value.
- Nibble selection: nib = shown[4*digit+3 : 4*digit].
- Hex encoding, active-low gfedcba:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78.
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- Blank condition for digit k: LEADING_ZERO_BLANK = 1, k ≠ 0, and nibbles k..3 of shown are all zero.
- Registered outputs, each edge, computed from the pre-edge digit and shown:
  - display_enable = 0 or digit blanked: an = 1111, seg = 7F, dp = 1.
  - Otherwise: an = all ones except bit digit = 0; seg = encode(nib); dp = 0 only when DP_SEPARATOR = 1 and digit == 2, else 1.
- frame_done is registered from the frame-boundary condition.
- No backpressure: update_req is always accepted. msb_in and lsb_in are sampled only on update_req cycles.

## Timing
- Reset values, applied at the next edge with reset = 0, including mid-frame:
  - cnt = 0, digit = 3, pending = 0, pending_valid = 0, shown = 0.
  - an = 1111, seg = 7F, dp = 1, frame_done = 0.
- Output latency: an, seg and dp reflect (digit, shown) one cycle after those states are established.
- Digit slot: REFRESH_DIV cycles. Frame: 4·REFRESH_DIV cycles.
- First frame_done: high in the cycle after edge 4·REFRESH_DIV following reset release. Thereafter one pulse every 4·REFRESH_DIV cycles.
- Update latency: update_req at any cycle of a frame → new digits begin with the digit-3 slot of the next frame. The first new-value output appears one cycle after the boundary edge.
- update_req on a boundary edge: the value appears in the immediately following frame.
- display_enable: takes effect on outputs one cycle after it changes. It does not affect cnt, digit, frame_done or the buffers.

## Test plan
All scenarios use REFRESH_DIV = 4 unless stated.
- Reset: hold reset = 0 for 3 cycles mid-scan, then release → an = 1111, seg = 7F, dp = 1, frame_done = 0 during reset. frame_done first pulses 16 edges after release.
- Update at frame boundary (LEADING_ZERO_BLANK = 0): update_req with msb_in = 12, lsb_in = AB mid-frame.
  - The old value is displayed until the boundary.
  - Next frame: an 0111/1011/1101/1110, seg 79/24/08/03, dp = 0 only in the 1011 slot.
- Leading-zero blanking (LEADING_ZERO_BLANK = 1): shown = 0005 → slots 3..1 give an = 1111, slot 0 gives an = 1110 with seg = 12. shown = 0000 → only digit 0 lit, seg = 40.
- Simultaneous events: update_req (value 00F0) on the same edge as the frame boundary → the next frame shows 00F0, and pending_valid = 0 afterwards.
- Last capture wins: two update_reqs in one frame (1111, then 2222) → the next frame shows 2222 only; no frame shows 1111.
- Display disable: display_enable = 0 for 20 cycles → an = 1111, seg = 7F, dp = 1 throughout. frame_done still pulses every 16 cycles. Re-enable → the correct digit appears one cycle later.
